// File: rtl/shift_out_buffer.sv
// Result buffer behind the 7-stage barrel shifter; optional SHIFT_OUT_BYPASS_EN forwards into an empty FIFO.
// Latency: result visible LAT edges after its accepting edge (LAT-1 via bypass); backpressure by credit on in_ready.

// sob_fifo: generic DEPTH-entry FIFO with registered count, any depth >= 1.
// Latency: one edge write-to-read; backpressure: writer must track credits, there is no full check.
module sob_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_vld_i,
  input  logic [W-1:0]  wr_dat_i,
  output logic          rd_vld_o,
  input  logic          rd_rdy_i,
  output logic [W-1:0]  rd_dat_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign rd_vld_o = (count_q != '0);
  assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;
  assign count_o  = count_q;

  always_comb begin
    pop      = rd_vld_o & rd_rdy_i;
    wr_ptr_d = wr_vld_i ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_vld_i, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the read side masks it whenever count is zero.
  always_ff @(posedge clk) begin
    if (wr_vld_i) mem_q[wr_ptr_q] <= wr_dat_i;
  end
endmodule

module shift_out_buffer #(
  parameter  int LAT   = 7,
  parameter  int DEPTH = 16,
  parameter  int TAG_W = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      shift_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [CW-1:0]    occupancy
);
  localparam int IW = $clog2(LAT + 1);
  localparam int EW = 32 + TAG_W;

  logic [LAT-1:0]   vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [TAG_W-1:0] tag_d [LAT];
  logic [IW-1:0]    inflight_q, inflight_d;
  logic             acc, arr;
  logic [TAG_W-1:0] tail_tag;
  logic             fifo_wr_vld, fifo_rd_vld;
  logic [EW-1:0]    fifo_rd_dat;
  logic [CW-1:0]    fifo_count;

  // Credits come only from registers so in_ready has no path from in_valid or out_ready.
  assign in_ready  = (int'(inflight_q) + int'(fifo_count)) < DEPTH;
  assign acc       = in_valid & in_ready;
  assign arr       = vld_q[LAT-1];
  assign tail_tag  = tag_q[LAT-1];
  assign occupancy = fifo_count;

  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = acc;
    tag_d[0] = in_tag;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    case ({acc, arr})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q      <= '0;
      inflight_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

`ifdef SHIFT_OUT_BYPASS_EN
  logic byp_vld;

  // An arriving result skips the FIFO only when it is empty and the consumer takes it now.
  assign byp_vld     = arr & ~fifo_rd_vld;
  assign fifo_wr_vld = arr & ~(byp_vld & out_ready);
  assign out_valid   = fifo_rd_vld | byp_vld;
  assign {out_data, out_tag} = fifo_rd_vld ? fifo_rd_dat
                             : (byp_vld ? {shift_o, tail_tag} : '0);
`else
  assign fifo_wr_vld = arr;
  assign out_valid   = fifo_rd_vld;
  assign {out_data, out_tag} = fifo_rd_dat;
`endif

  sob_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_vld_i (fifo_wr_vld),
    .wr_dat_i ({shift_o, tail_tag}),
    .rd_vld_o (fifo_rd_vld),
    .rd_rdy_i (out_ready),
    .rd_dat_o (fifo_rd_dat),
    .count_o  (fifo_count)
  );
endmodule

// File: tb/tb_shift_out_buffer.sv
// Directed bench for shift_out_buffer with a behavioural 7-stage shifter (rotate-left by one) feeding shift_o.
module tb_shift_out_buffer;
  localparam int LAT   = 7;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
`ifdef SHIFT_OUT_BYPASS_EN
  localparam int FIRST = LAT - 1;
`else
  localparam int FIRST = LAT;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      in_i;
  logic [31:0]      shift_o;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       occupancy;
  logic [31:0]      pipe [LAT];

  int checks = 0;
  int errors = 0;
  int idx, first, bubbles, drops, acc_n, unstable, stale;

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= in_i;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign shift_o = rotl1(pipe[LAT-1]);

  shift_out_buffer #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .shift_o   (shift_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_i = '0; in_tag = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    reset = 1'b0;

    // Single request
    in_valid = 1'b1; in_i = 32'h8000_0001; in_tag = 4'd3;
    tick();
    in_valid = 1'b0; in_i = '0;
    repeat (LAT - 1) tick();
    settle();
`ifdef SHIFT_OUT_BYPASS_EN
    chk("s1_byp_valid", 32'(out_valid), 32'd1);
    chk("s1_byp_data", out_data, 32'h0000_0003);
    chk("s1_byp_tag", 32'(out_tag), 32'd3);
    chk("s1_byp_occ", 32'(occupancy), 32'd0);
    tick(); settle();
    chk("s1_after_valid", 32'(out_valid), 32'd0);
    chk("s1_after_occ", 32'(occupancy), 32'd0);
`else
    chk("s1_early_valid", 32'(out_valid), 32'd0);
    tick(); settle();
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_data", out_data, 32'h0000_0003);
    chk("s1_tag", 32'(out_tag), 32'd3);
    chk("s1_occ", 32'(occupancy), 32'd1);
`endif
    tick(); settle();
    chk("s1_drained_valid", 32'(out_valid), 32'd0);
    chk("s1_drained_occ", 32'(occupancy), 32'd0);

    // 20 back-to-back requests, consumer always ready
    idx = 0; first = -1; bubbles = 0; drops = 0;
    if (!in_ready) drops++;
    in_valid = 1'b1; in_i = 32'h1000_0000; in_tag = 4'd0;
    tick();
    for (int c = 0; c < 40; c++) begin
      settle();
      if (out_valid) begin
        if (first < 0) first = c;
        if (idx < 20) begin
          chk("s2_data", out_data, rotl1(32'h1000_0000 + 32'(idx)));
          chk("s2_tag", 32'(out_tag), 32'(idx % 16));
        end
        idx++;
      end else if (first >= 0 && idx < 20) begin
        bubbles++;
      end
      if (c + 1 < 20) begin
        if (!in_ready) drops++;
        in_valid = 1'b1; in_i = 32'h1000_0000 + 32'(c + 1); in_tag = TAG_W'((c + 1) % 16);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    chk("s2_first_latency", 32'(first), 32'(FIRST));
    chk("s2_result_count", 32'(idx), 32'd20);
    chk("s2_bubbles", 32'(bubbles), 32'd0);
    chk("s2_in_ready_drops", 32'(drops), 32'd0);

    // Consumer stalled, requests held: credits must stop at DEPTH
    out_ready = 1'b0; in_valid = 1'b1; acc_n = 0; unstable = 0;
    for (int c = 0; c < 40; c++) begin
      settle();
      if (out_valid && out_data !== rotl1(32'h2000_0000)) unstable++;
      if (in_ready) begin
        in_i = 32'h2000_0000 + 32'(acc_n); in_tag = TAG_W'(acc_n % 16);
        acc_n++;
      end else begin
        in_i = 32'hDEAD_BEEF;
      end
      tick();
    end
    settle();
    chk("s3_accepts", 32'(acc_n), 32'd16);
    chk("s3_in_ready", 32'(in_ready), 32'd0);
    chk("s3_occupancy", 32'(occupancy), 32'd16);
    chk("s3_out_valid", 32'(out_valid), 32'd1);
    chk("s3_stable", 32'(unstable), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1; idx = 0;
    for (int c = 0; c < 30; c++) begin
      settle();
      if (out_valid) begin
        if (idx < 16) begin
          chk("s3_drain_data", out_data, rotl1(32'h2000_0000 + 32'(idx)));
          chk("s3_drain_tag", 32'(out_tag), 32'(idx % 16));
        end
        idx++;
      end
      tick();
    end
    settle();
    chk("s3_drain_count", 32'(idx), 32'd16);
    chk("s3_drain_occ", 32'(occupancy), 32'd0);
    chk("s3_drain_in_ready", 32'(in_ready), 32'd1);

    // Pop and arrival in the same cycle at count 2
    out_ready = 1'b0;
    in_valid = 1'b1; in_i = 32'h3000_0000; in_tag = 4'd5;
    tick();
    in_i = 32'h3000_0001; in_tag = 4'd6;
    tick();
    in_i = 32'h3000_0002; in_tag = 4'd7;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    settle();
    chk("s4_occ_before", 32'(occupancy), 32'd2);
    chk("s4_data_a", out_data, rotl1(32'h3000_0000));
    chk("s4_tag_a", 32'(out_tag), 32'd5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    settle();
    chk("s4_occ_same", 32'(occupancy), 32'd2);
    chk("s4_data_b", out_data, rotl1(32'h3000_0001));
    chk("s4_tag_b", 32'(out_tag), 32'd6);
    out_ready = 1'b1;
    tick(); settle();
    chk("s4_occ_one", 32'(occupancy), 32'd1);
    chk("s4_data_c", out_data, rotl1(32'h3000_0002));
    chk("s4_tag_c", 32'(out_tag), 32'd7);
    tick(); settle();
    chk("s4_occ_empty", 32'(occupancy), 32'd0);
    chk("s4_valid_empty", 32'(out_valid), 32'd0);

    // Reset with 5 in flight and 3 buffered
    out_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1; in_i = 32'h4000_0000 + 32'(j); in_tag = TAG_W'(j);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    settle();
    chk("s5_occ_pre", 32'(occupancy), 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("s5_rst_valid", 32'(out_valid), 32'd0);
    chk("s5_rst_occ", 32'(occupancy), 32'd0);
    chk("s5_rst_in_ready", 32'(in_ready), 32'd1);
    chk("s5_rst_data", out_data, 32'd0);
    chk("s5_rst_tag", 32'(out_tag), 32'd0);
    tick();
    reset = 1'b0; out_ready = 1'b1; stale = 0;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (out_valid) stale++;
      tick();
    end
    chk("s5_no_stale", 32'(stale), 32'd0);
    chk("s5_final_occ", 32'(occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
